// File: rtl/ycr_sram_ctrl_if.sv
// rtl/ycr_sram_ctrl_if.sv - request/response channel bundle for ycr_sram_ctrl
//
// Purpose: groups the initiator request channel, the in-order read response
// channel and the init status flag of ycr_sram_ctrl.
// Ports (signals):
//   req_valid/req_ready/req_we/req_addr/req_wdata/req_be : request channel
//   rsp_valid/rsp_ready/rsp_rdata                        : read response channel
//   init_done                                            : controller reached RUN
// Modports: master = requester side, slave = controller side.

interface ycr_sram_ctrl_if #(
  parameter int ADDR_WIDTH = 9,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_WMASKS = 4
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic [NUM_WMASKS-1:0] req_be;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DATA_WIDTH-1:0] rsp_rdata;
  logic                  init_done;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, init_done
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, init_done
  );
endinterface

// File: rtl/ycr_sram_ctrl.sv
// rtl/ycr_sram_ctrl.sv - port-0 (1RW) controller for the 32x512 byte-masked sky130 SRAM
//
// Purpose: turns valid/ready read and masked-write requests into the macro's
// active-low csb0/web0 pin protocol, captures read data at the macro's
// two-edge latency into a 4-entry in-order response FIFO, and optionally
// zero-fills the whole array after reset before accepting traffic.
// Ports:
//   clk, rst_n       : clock (also macro clk0), async active-low reset
//   bus (slave)      : request channel, response channel, init_done
//   sram_csb0/web0   : macro chip select / write enable, active low
//   sram_wmask0      : macro byte write mask
//   sram_addr0/din0  : macro address / write data
//   sram_dout0       : macro read data

module ycr_sram_ctrl #(
  parameter int ADDR_WIDTH = 9,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_WMASKS = 4,
  parameter bit INIT_EN    = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  ycr_sram_ctrl_if.slave        bus,
  output logic                  sram_csb0,
  output logic                  sram_web0,
  output logic [NUM_WMASKS-1:0] sram_wmask0,
  output logic [ADDR_WIDTH-1:0] sram_addr0,
  output logic [DATA_WIDTH-1:0] sram_din0,
  input  logic [DATA_WIDTH-1:0] sram_dout0
);
  localparam int RAM_DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] INIT_END = (ADDR_WIDTH+1)'(RAM_DEPTH);

  localparam logic [0:0] ST_INIT = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  logic [0:0]            state;
  logic [ADDR_WIDTH:0]   init_cnt;
  logic [2:0]            outstanding;
  logic [1:0]            rd_tag;
  logic [DATA_WIDTH-1:0] fifo_mem [0:3];
  logic [1:0]            wr_ptr;
  logic [1:0]            rd_ptr;
  logic [2:0]            fifo_cnt;

  logic run;
  logic accept;
  logic rd_accept;
  logic init_issue;
  logic push;
  logic pop;

  assign run           = (state == ST_RUN);
  assign bus.req_ready = run && (outstanding < 3'd4);
  assign accept        = bus.req_valid && bus.req_ready;
  assign rd_accept     = accept && !bus.req_we;
  // init_cnt carries one extra bit so the "all words written" condition is
  // a plain compare against RAM_DEPTH
  assign init_issue    = (state == ST_INIT) && INIT_EN && (init_cnt != INIT_END);
  // tag that left the 2-deep pipe marks the cycle whose macro output is valid now
  assign push          = rd_tag[1];
  assign pop           = bus.rsp_valid && bus.rsp_ready;

  assign bus.rsp_valid = (fifo_cnt != 3'd0);
  assign bus.rsp_rdata = bus.rsp_valid ? fifo_mem[rd_ptr] : '0;
  assign bus.init_done = run;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_INIT;
      init_cnt <= '0;
    end else if (state == ST_INIT) begin
      if (!INIT_EN || (init_cnt == INIT_END)) begin
        state <= ST_RUN;
      end else begin
        init_cnt <= init_cnt + 1'b1;
      end
    end
  end

  // Macro pins are registered; addr0/din0 hold when idle so the bus does not toggle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sram_csb0   <= 1'b1;
      sram_web0   <= 1'b1;
      sram_wmask0 <= '0;
      sram_addr0  <= '0;
      sram_din0   <= '0;
    end else if (init_issue) begin
      sram_csb0   <= 1'b0;
      sram_web0   <= 1'b0;
      sram_wmask0 <= '1;
      sram_addr0  <= init_cnt[ADDR_WIDTH-1:0];
      sram_din0   <= '0;
    end else if (accept) begin
      sram_csb0   <= 1'b0;
      sram_web0   <= ~bus.req_we;
      sram_wmask0 <= bus.req_we ? bus.req_be : '0;
      sram_addr0  <= bus.req_addr;
      sram_din0   <= bus.req_wdata;
    end else begin
      sram_csb0   <= 1'b1;
      sram_web0   <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_tag      <= '0;
      outstanding <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      fifo_cnt    <= '0;
    end else begin
      rd_tag <= {rd_tag[0], rd_accept};
      case ({rd_accept, pop})
        2'b10:   outstanding <= outstanding + 1'b1;
        2'b01:   outstanding <= outstanding - 1'b1;
        default: outstanding <= outstanding;
      endcase
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
        2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  // Outstanding limit of 4 guarantees a free slot on every push
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= sram_dout0;
  end
endmodule

// File: tb/tb_ycr_sram_ctrl.sv
// tb/tb_ycr_sram_ctrl.sv - randomized self-checking bench for ycr_sram_ctrl

module tb_ycr_sram_ctrl;
  logic        clk;
  logic        rst_n;
  logic        sram_csb0;
  logic        sram_web0;
  logic [3:0]  sram_wmask0;
  logic [8:0]  sram_addr0;
  logic [31:0] sram_din0;
  logic [31:0] sram_dout0;

  ycr_sram_ctrl_if #(.ADDR_WIDTH(9), .DATA_WIDTH(32), .NUM_WMASKS(4)) bus ();

  ycr_sram_ctrl #(.ADDR_WIDTH(9), .DATA_WIDTH(32), .NUM_WMASKS(4), .INIT_EN(1'b1)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .sram_csb0   (sram_csb0),
    .sram_web0   (sram_web0),
    .sram_wmask0 (sram_wmask0),
    .sram_addr0  (sram_addr0),
    .sram_din0   (sram_din0),
    .sram_dout0  (sram_dout0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Macro model: samples pins at posedge, writes/reads at the following negedge
  logic [31:0] sram_mem [0:511];
  logic        filled = 1'b0;
  logic        lat_rd, lat_wr;
  logic [8:0]  lat_a;
  logic [31:0] lat_d;
  logic [3:0]  lat_m;

  always @(posedge clk) begin
    lat_rd <= !sram_csb0 && sram_web0;
    lat_wr <= !sram_csb0 && !sram_web0;
    lat_a  <= sram_addr0;
    lat_d  <= sram_din0;
    lat_m  <= sram_wmask0;
  end

  always @(negedge clk) begin
    if (!filled) begin
      for (int i = 0; i < 512; i++) sram_mem[i] <= $urandom;
      filled <= 1'b1;
    end else begin
      if (lat_wr)
        for (int b = 0; b < 4; b++)
          if (lat_m[b]) sram_mem[lat_a][8*b +: 8] <= lat_d[8*b +: 8];
      if (lat_rd) sram_dout0 <= sram_mem[lat_a];
    end
  end

  // Reference model: expected array contents plus queue of pending read results
  logic [31:0] ref_mem [0:511];
  logic [31:0] exp_q [$];
  int          exp_t [$];
  int          cyc;
  int          n_total;
  int          n_bad;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Called at a negedge: drive one cycle, check outputs, advance the model
  task automatic cyc_step(input logic v, input logic we, input logic [8:0] a,
                          input logic [31:0] d, input logic [3:0] be, input logic rr,
                          output logic acc);
    logic exp_ready, exp_valid, pop;
    bus.req_valid = v;
    bus.req_we    = we;
    bus.req_addr  = a;
    bus.req_wdata = d;
    bus.req_be    = be;
    bus.rsp_ready = rr;
    #1;
    exp_ready = (exp_q.size() < 4);
    exp_valid = (exp_q.size() > 0) && (exp_t[0] <= cyc);
    check("req_ready", bus.req_ready, exp_ready);
    check("rsp_valid", bus.rsp_valid, exp_valid);
    if (exp_valid) check("rsp_rdata", bus.rsp_rdata, exp_q[0]);
    acc = v && exp_ready;
    pop = rr && exp_valid;
    @(posedge clk);
    cyc++;
    if (pop) begin
      void'(exp_q.pop_front());
      void'(exp_t.pop_front());
    end
    if (acc) begin
      if (we) begin
        for (int b = 0; b < 4; b++)
          if (be[b]) ref_mem[a][8*b +: 8] = d[8*b +: 8];
      end else begin
        exp_q.push_back(ref_mem[a]);
        exp_t.push_back(cyc + 2);
      end
    end
    @(negedge clk);
    check("sram_csb0", sram_csb0, !acc);
    if (acc) begin
      check("sram_web0", sram_web0, !we);
      check("sram_addr0", sram_addr0, a);
      check("sram_din0", sram_din0, d);
      check("sram_wmask0", sram_wmask0, we ? be : 4'h0);
    end
  endtask

  task automatic idle(input int n);
    logic acc;
    for (int i = 0; i < n; i++) cyc_step(1'b0, 1'b0, 9'h0, 32'h0, 4'h0, 1'b1, acc);
  endtask

  // Called at a negedge right after rst_n rises: follows the zero-fill sweep
  task automatic run_init();
    int bad_pins;
    bad_pins = 0;
    for (int i = 0; i < 512; i++) ref_mem[i] = 32'h0;
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b1;
    bus.req_addr  = 9'h1;
    bus.req_wdata = 32'hFFFF_FFFF;
    bus.req_be    = 4'hF;
    bus.rsp_ready = 1'b1;
    for (int k = 1; k <= 513; k++) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
      if (k <= 512) begin
        if (sram_csb0 !== 1'b0 || sram_web0 !== 1'b0 || sram_wmask0 !== 4'hF ||
            sram_din0 !== 32'h0 || sram_addr0 !== 9'(k - 1))
          bad_pins++;
      end
      if (k == 512) begin
        check("init_done_512", bus.init_done, 1'b0);
        check("req_ready_init", bus.req_ready, 1'b0);
      end
      if (k == 513) begin
        check("init_csb_end", sram_csb0, 1'b1);
        check("init_done_513", bus.init_done, 1'b1);
        check("req_ready_run", bus.req_ready, 1'b1);
      end
    end
    check("init_pin_errors", 32'(bad_pins), 32'h0);
    bus.req_valid = 1'b0;
  endtask

  initial begin
    logic        acc;
    int          n_acc;
    logic [8:0]  ra;
    logic [31:0] rd;
    logic [3:0]  rb;
    n_total = 0;
    n_bad   = 0;
    cyc     = 0;
    rst_n   = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.req_be    = '0;
    bus.rsp_ready = 1'b0;
    repeat (3) @(negedge clk);

    check("rst_csb0", sram_csb0, 1'b1);
    check("rst_web0", sram_web0, 1'b1);
    check("rst_wmask0", sram_wmask0, 4'h0);
    check("rst_addr0", sram_addr0, 9'h0);
    check("rst_din0", sram_din0, 32'h0);
    check("rst_req_ready", bus.req_ready, 1'b0);
    check("rst_rsp_valid", bus.rsp_valid, 1'b0);
    check("rst_rsp_rdata", bus.rsp_rdata, 32'h0);
    check("rst_init_done", bus.init_done, 1'b0);

    rst_n = 1'b1;
    run_init();

    // Zero-filled top word
    cyc_step(1'b1, 1'b0, 9'h1FF, 32'h0, 4'h0, 1'b1, acc);
    idle(4);

    // Write then read-after-write on consecutive cycles
    cyc_step(1'b1, 1'b1, 9'h005, 32'hDEADBEEF, 4'hF, 1'b1, acc);
    cyc_step(1'b1, 1'b0, 9'h005, 32'h0, 4'h0, 1'b1, acc);
    idle(4);

    // Byte mask over a zeroed word
    cyc_step(1'b1, 1'b1, 9'h010, 32'h11223344, 4'b0101, 1'b1, acc);
    cyc_step(1'b1, 1'b0, 9'h010, 32'h0, 4'h0, 1'b1, acc);
    idle(4);

    // Streaming: 8 back-to-back reads
    for (int i = 0; i < 8; i++)
      cyc_step(1'b1, 1'b1, 9'(i), 32'h100 + 32'(i), 4'hF, 1'b1, acc);
    n_acc = 0;
    for (int i = 0; i < 8; i++) begin
      cyc_step(1'b1, 1'b0, 9'(i), 32'h0, 4'h0, 1'b1, acc);
      if (acc) n_acc++;
    end
    check("stream_accepts", 32'(n_acc), 32'd8);
    idle(5);

    // Backpressure: only 4 reads may be in flight
    n_acc = 0;
    for (int i = 0; i < 8; i++) begin
      cyc_step(1'b1, 1'b0, 9'(i), 32'h0, 4'h0, 1'b0, acc);
      if (acc) n_acc++;
    end
    check("bp_accepts", 32'(n_acc), 32'd4);
    idle(6);

    // Random traffic over a small address window to exercise RAW reuse
    for (int i = 0; i < 400; i++) begin
      ra = ($urandom_range(0, 7) == 0) ? 9'h1FF : 9'($urandom_range(0, 15));
      rd = $urandom;
      rb = 4'($urandom_range(0, 15));
      cyc_step($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, ra, rd, rb,
               $urandom_range(0, 3) != 0, acc);
    end
    for (int i = 0; i < 20 && exp_q.size() > 0; i++) idle(1);
    check("drain", 32'(exp_q.size()), 32'd0);

    // Reset with two reads in flight
    cyc_step(1'b1, 1'b0, 9'h001, 32'h0, 4'h0, 1'b0, acc);
    cyc_step(1'b1, 1'b0, 9'h002, 32'h0, 4'h0, 1'b0, acc);
    bus.req_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_rsp_valid", bus.rsp_valid, 1'b0);
    check("mid_rst_csb0", sram_csb0, 1'b1);
    check("mid_rst_web0", sram_web0, 1'b1);
    check("mid_rst_req_ready", bus.req_ready, 1'b0);
    check("mid_rst_init_done", bus.init_done, 1'b0);
    exp_q.delete();
    exp_t.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    run_init();
    idle(6);
    cyc_step(1'b1, 1'b0, 9'h005, 32'h0, 4'h0, 1'b1, acc);
    idle(4);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
